// File: rtl/multicycle_controller.sv
// Multicycle RISC-V main controller.
// Moore FSM driving datapath enables and mux selects.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       zero,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    state_t state_q;
    state_t state_d;

    logic is_lw;
    logic is_sw;
    logic is_r;
    logic is_i;
    logic is_jal;
    logic is_beq;

    logic pc_update;
    logic branch;
    logic ir_en;
    logic reg_en;
    logic mem_en;
    logic bad_op;

    assign is_lw  = (op == 7'b0000011);
    assign is_sw  = (op == 7'b0100011);
    assign is_r   = (op == 7'b0110011);
    assign is_i   = (op == 7'b0010011);
    assign is_jal = (op == 7'b1101111);
    assign is_beq = (op == 7'b1100011);

    // State register; async reset parks the FSM in FETCH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state Moore outputs.
    always_comb begin
        state_d    = FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_en      = 1'b0;
        reg_en     = 1'b0;
        mem_en     = 1'b0;
        bad_op     = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            FETCH: begin
                state_d    = DECODE;
                ir_en      = 1'b1;
                pc_update  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                unique case (1'b1)
                    is_lw, is_sw: state_d = MEMADR;
                    is_r:         state_d = EXECUTER;
                    is_i:         state_d = EXECUTEI;
                    is_jal:       state_d = JAL;
                    is_beq:       state_d = BEQ;
                    default: begin
                        state_d = FETCH;
                        bad_op  = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                state_d   = is_lw ? MEMREAD : MEMWRITE;
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD: begin
                state_d = MEMWB;
                adr_src = 1'b1;
            end
            MEMWB: begin
                state_d    = FETCH;
                result_src = 2'b01;
                reg_en     = 1'b1;
            end
            MEMWRITE: begin
                state_d = FETCH;
                adr_src = 1'b1;
                mem_en  = 1'b1;
            end
            EXECUTER: begin
                state_d   = ALUWB;
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECUTEI: begin
                state_d   = ALUWB;
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                state_d = FETCH;
                reg_en  = 1'b1;
            end
            JAL: begin
                state_d   = ALUWB;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            BEQ: begin
                state_d   = FETCH;
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Enables are held low while reset is asserted.
    always_comb begin
        pc_write  = reset_n & (pc_update | (branch & zero));
        ir_write  = reset_n & ir_en;
        reg_write = reset_n & reg_en;
        mem_write = reset_n & mem_en;
        illegal   = reset_n & bad_op;
    end

    assign state = state_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have no parameters; all widths fixed.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 op  input  7  opcode field from the instruction register; stable from DECODE until return to FETCH.
REQ-005 zero  input  1  ALU zero flag, valid in BEQ.
REQ-006 pc_write  output  1  enable for the PC flip-flop.
REQ-007 ir_write  output  1  enable for the instruction register and old-PC flip-flops.
REQ-008 reg_write  output  1  register-file write enable.
REQ-009 mem_write  output  1  memory write enable.
REQ-010 adr_src  output  1  memory address mux: 0=PC, 1=result.
REQ-011 result_src  output  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult.
REQ-012 alu_src_a  output  2  ALU A mux: 00=PC, 01=OldPC, 10=rs1 data.
REQ-013 alu_src_b  output  2  ALU B mux: 00=rs2 data, 01=ImmExt, 10=constant 4.
REQ-014 alu_op  output  2  to ALU decoder: 00=add, 01=subtract/compare, 10=funct-decoded.
REQ-015 illegal  output  1  high for the DECODE cycle when op is unsupported.
REQ-016 state  output  4  current state encoding, for debug.

Function
REQ-017 SHALL be a Moore FSM; all outputs are a combinational function of state, except pc_write, illegal and reset gating.
REQ-018 SHALL use state encodings FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10; codes 11-15 SHALL go to FETCH on the next edge with all enables 0.
REQ-019 SHALL decode op values: lw=0000011, sw=0100011, R-type=0110011, I-ALU=0010011, jal=1101111, beq=1100011.
REQ-020 SHALL follow these transitions:
- FETCH->DECODE.
- DECODE: lw/sw->MEMADR, R-type->EXECUTER, I-ALU->EXECUTEI, jal->JAL, beq->BEQ, otherwise FETCH with illegal=1.
- MEMADR: lw->MEMREAD, otherwise MEMWRITE.
- MEMREAD->MEMWB.
- EXECUTER, EXECUTEI and JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ->FETCH.
REQ-021 SHALL drive these outputs per state; unlisted outputs are 0:
- FETCH: ir_write=1, pc_update=1, alu_src_b=10, result_src=10.
- DECODE: alu_src_a=01, alu_src_b=01.
- MEMADR: alu_src_a=10, alu_src_b=01.
- MEMREAD: adr_src=1.
- MEMWB: result_src=01, reg_write=1.
- MEMWRITE: adr_src=1, mem_write=1.
- EXECUTER: alu_src_a=10, alu_op=10.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10.
- ALUWB: reg_write=1.
- JAL: alu_src_a=01, alu_src_b=10, pc_update=1.
- BEQ: alu_src_a=10, alu_op=01, branch=1.
REQ-022 SHALL compute pc_write = pc_update | (branch & zero); pc_update and branch are internal signals.
REQ-023 Instruction latency in cycles SHALL be: lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3, illegal 2.
REQ-024 zero SHALL be ignored in every state except BEQ.

Reset
REQ-025 Asserting reset_n=0 SHALL immediately force state to FETCH, independent of clk.
REQ-026 While reset_n=0, pc_write, ir_write, reg_write, mem_write and illegal SHALL be 0; mux selects SHALL show FETCH values.
REQ-027 Reset asserted mid-instruction SHALL abandon the instruction with no further writes.
REQ-028 The first posedge after release SHALL execute FETCH with all its enables asserted.

Verification
REQ-029 Reset release, op=0000011 held -> states 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01; pc_write=1 only in state 0.
REQ-030 op=0100011 -> states 0,1,2,5,0; mem_write=1 and adr_src=1 only in state 5; reg_write never 1.
REQ-031 op=1100011 with zero=1 in BEQ -> pc_write=1 in BEQ, alu_op=01; repeat with zero=0 -> pc_write=0 in BEQ.
REQ-032 op=1101111 -> states 0,1,9,7,0; pc_write=1 in states 0 and 9; reg_write=1 in state 7.
REQ-033 op=1111111 -> illegal=1 in DECODE, then next state 0; no reg_write or mem_write asserted.
REQ-034 reset_n pulsed low during MEMREAD -> state=0 immediately and all enables 0 while low; normal fetch resumes after release.
